// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// mux_scan_pkg : shared constants and state encoding for the mux scan sequencer
// Rev 1.0
// ============================================================================
package mux_scan_pkg;

   localparam int NUM_CH  = 6;
   localparam int SEL_W   = 3;
   localparam int DWELL_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/chan_next_enabled.sv
`default_nettype none
// ============================================================================
// chan_next_enabled : lowest enabled channel strictly above idx_i (idx_i = -1
// yields the first enabled channel). Rev 1.0
// ============================================================================
module chan_next_enabled
   import mux_scan_pkg::*;
(
   input  logic [NUM_CH-1:0] mask_i,
   input  logic [SEL_W:0]    idx_i,
   output logic [SEL_W-1:0]  next_o,
   output logic              found_o
);

   // Descending walk so the last hit, i.e. the lowest qualifying index, wins.
   always_comb begin
      next_o  = '0;
      found_o = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_i[i] && ($signed(idx_i) < $signed((SEL_W + 1)'(i)))) begin
            next_o  = SEL_W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// mux_scan_sequencer : steps a 6:1 mux through enabled channels, samples each
// after a settle time and hands a snapshot downstream on valid/ready. Rev 1.0
// ============================================================================
module mux_scan_sequencer
   import mux_scan_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               cont,
   input  logic [NUM_CH-1:0]  cfg_mask,
   input  logic [DWELL_W-1:0] cfg_dwell,
   output logic [SEL_W-1:0]   sel,
   input  logic               mux_in,
   output logic [NUM_CH-1:0]  frame_data,
   output logic               frame_valid,
   input  logic               frame_ready,
   output logic               busy
);

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [DWELL_W-1:0]  cnt_q, cnt_d;
   logic [DWELL_W-1:0]  dwell_q, dwell_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [NUM_CH-1:0]   shadow_q, shadow_d;
   logic [NUM_CH-1:0]   data_q, data_d;
   logic                valid_q, valid_d;

   logic [SEL_W-1:0]    first_idx, next_idx;
   logic                first_found, next_found;
   logic                launch_idle, handshake, relaunch, launch, sample;
   logic [NUM_CH-1:0]   merged;

   chan_next_enabled u_first (
      .mask_i  (cfg_mask),
      .idx_i   ('1),
      .next_o  (first_idx),
      .found_o (first_found)
   );

   chan_next_enabled u_next (
      .mask_i  (mask_q),
      .idx_i   ({1'b0, sel_q}),
      .next_o  (next_idx),
      .found_o (next_found)
   );

   assign launch_idle = (state_q == ST_IDLE) && start && first_found;
   assign handshake   = (state_q == ST_DONE) && valid_q && frame_ready;
   assign relaunch    = handshake && cont && first_found;
   assign launch      = launch_idle || relaunch;
   assign sample      = (state_q == ST_SCAN) && (cnt_q == dwell_q);
   assign merged      = shadow_q | (NUM_CH'(mux_in) << sel_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (launch_idle) state_d = ST_SCAN;
         ST_SCAN: if (sample && !next_found) state_d = ST_DONE;
         ST_DONE: if (handshake) state_d = relaunch ? ST_SCAN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != ST_IDLE);
   end

   always_comb begin
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      dwell_d  = dwell_q;
      mask_d   = mask_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      valid_d  = valid_q;

      if (handshake) begin
         valid_d = 1'b0;
      end

      if (launch) begin
         mask_d   = cfg_mask;
         dwell_d  = cfg_dwell;
         shadow_d = '0;
         sel_d    = first_idx;
         cnt_d    = '0;
      end else if (state_q == ST_SCAN) begin
         if (!sample) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            shadow_d = merged;
            cnt_d    = '0;
            if (next_found) begin
               sel_d = next_idx;
            end else begin
               data_d  = merged;
               valid_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q    <= '0;
         cnt_q    <= '0;
         dwell_q  <= '0;
         mask_q   <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         sel_q    <= sel_d;
         cnt_q    <= cnt_d;
         dwell_q  <= dwell_d;
         mask_q   <= mask_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   assign sel         = sel_q;
   assign frame_data  = data_q;
   assign frame_valid = valid_q;

endmodule
`default_nettype wire
